ltcwin: RTL and testbench

// - Window assembler upstream of the lattice propagation stage: accepts the lattice as a raster stream of
//   64-bit words (8 cells x 8 bits), holds two rows in line buffers, and emits the 3x3 neighbourhood of

---
 rtl/ltcwin.sv | 187 ++++++++++++++++++
 tb/tb_ltcwin.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ltcwin.sv
// ltcwin: 3x3 lattice-word window assembler over a raster word stream.
// Define LTCWIN_WALL_EN to fill out-of-lattice neighbours with WALL_WORD.
module ltcwin #(
  parameter int          COLS      = 4,
  parameter int          ROWS      = 8,
  parameter logic [63:0] WALL_WORD = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      frame_done,
  input  logic [63:0]               in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [63:0]               win_v0,
  output logic [63:0]               win_v1,
  output logic [63:0]               win_v2,
  output logic [63:0]               win_v3,
  output logic [63:0]               win_v4,
  output logic [63:0]               win_v5,
  output logic [63:0]               win_v6,
  output logic [63:0]               win_v7,
  output logic [63:0]               win_v8,
  output logic [$clog2(ROWS)-1:0]   win_row,
  output logic [$clog2(COLS)-1:0]   win_col,
  output logic                      win_valid,
  input  logic                      win_ready
);

  localparam int VRW = $clog2(ROWS + 1);
  localparam int VCW = $clog2(COLS + 1);
  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);

  localparam logic [VRW-1:0] VR_END = VRW'(ROWS);
  localparam logic [VCW-1:0] VC_END = VCW'(COLS);
  localparam logic [RW-1:0]  R_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0]  C_LAST = CW'(COLS - 1);

`ifdef LTCWIN_WALL_EN
  localparam logic [63:0] FILL = WALL_WORD;
`else
  // empty boundary; the wall word is masked off
  localparam logic [63:0] FILL = WALL_WORD & 64'h0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [VRW-1:0]     vr;
  logic [VCW-1:0]     vc;
  logic               scan_end;
  logic [63:0]        lb1 [0:COLS];
  logic [63:0]        lb2 [0:COLS];
  logic [2:0][63:0]   c0, c1;
  logic [8:0][63:0]   wv, nv;
  logic               pad, slot_free, adv, load, last_hs;
  logic [63:0]        word;

  assign win_v0 = wv[0];
  assign win_v1 = wv[1];
  assign win_v2 = wv[2];
  assign win_v3 = wv[3];
  assign win_v4 = wv[4];
  assign win_v5 = wv[5];
  assign win_v6 = wv[6];
  assign win_v7 = wv[7];
  assign win_v8 = wv[8];

  // scan position qualifiers and advance condition
  always_comb begin
    pad       = (vr == VR_END) || (vc == VC_END);
    slot_free = !win_valid || win_ready;
    adv       = (state_q == RUN) && !scan_end
                && (pad || in_valid) && slot_free;
    word      = pad ? FILL : in_data;
    load      = adv && (vr != '0) && (vc != '0);
    last_hs   = win_valid && win_ready
                && (win_row == R_LAST) && (win_col == C_LAST);
  end

  // next window: columns C-1,C from shift regs, C+1 from buffers/new word
  always_comb begin
    nv[0] = c0[0];
    nv[1] = c1[0];
    nv[2] = lb2[vc];
    nv[3] = c0[1];
    nv[4] = c1[1];
    nv[5] = lb1[vc];
    nv[6] = c0[2];
    nv[7] = c1[2];
    nv[8] = word;
    if (vr == VRW'(1)) begin
      nv[0] = FILL;
      nv[1] = FILL;
      nv[2] = FILL;
    end
    if (vc == VCW'(1)) begin
      nv[0] = FILL;
      nv[3] = FILL;
      nv[6] = FILL;
    end
    if (vc == VC_END) begin
      nv[2] = FILL;
      nv[5] = FILL;
      nv[8] = FILL;
    end
    if (vr == VR_END) begin
      nv[6] = FILL;
      nv[7] = FILL;
      nv[8] = FILL;
    end
  end

  // frame FSM next state and handshake outputs
  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    frame_done = 1'b0;
    in_ready   = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy     = 1'b1;
        in_ready = !scan_end && !pad && slot_free;
        if (last_hs) state_d = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // virtual grid scan counters, cleared whenever not running
  always_ff @(posedge clk) begin
    if (rst || state_q != RUN) begin
      vr       <= '0;
      vc       <= '0;
      scan_end <= 1'b0;
    end else if (adv) begin
      if (vc == VC_END) begin
        vc <= '0;
        if (vr == VR_END) scan_end <= 1'b1;
        else              vr <= vr + VRW'(1);
      end else begin
        vc <= vc + VCW'(1);
      end
    end
  end

  // line buffers and column shift window; stale data is masked by fill
  always_ff @(posedge clk) begin
    if (adv) begin
      lb2[vc] <= lb1[vc];
      lb1[vc] <= word;
      c0      <= c1;
      c1      <= {word, lb1[vc], lb2[vc]};
    end
  end

  // output window register with valid/ready hold
  always_ff @(posedge clk) begin
    if (rst) begin
      wv        <= '0;
      win_row   <= '0;
      win_col   <= '0;
      win_valid <= 1'b0;
    end else if (load) begin
      wv        <= nv;
      win_row   <= RW'(vr - VRW'(1));
      win_col   <= CW'(vc - VCW'(1));
      win_valid <= 1'b1;
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ltcwin.sv
// tb_ltcwin: randomized scoreboard bench for the ltcwin window assembler.
// Expected windows come from a direct neighbourhood model of each frame.
module tb_ltcwin;

  localparam int COLS = 4;
  localparam int ROWS = 8;
  localparam int N    = COLS * ROWS;
  localparam logic [63:0] WALL = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef LTCWIN_WALL_EN
  localparam logic [63:0] FILL = WALL;
`else
  localparam logic [63:0] FILL = 64'h0;
`endif

  typedef struct packed {
    logic [8:0][63:0] v;
    logic [2:0]       r;
    logic [1:0]       c;
  } win_t;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, win_ready;
  logic        busy, frame_done, in_ready, win_valid;
  logic [63:0] in_data;
  logic [63:0] v0, v1, v2, v3, v4, v5, v6, v7, v8;
  logic [2:0]  win_row;
  logic [1:0]  win_col;
  logic [8:0][63:0] gv;

  assign gv = {v8, v7, v6, v5, v4, v3, v2, v1, v0};

  always #5 clk = ~clk;

  ltcwin #(.COLS(COLS), .ROWS(ROWS), .WALL_WORD(WALL)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .frame_done(frame_done), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .win_v0(v0), .win_v1(v1), .win_v2(v2), .win_v3(v3),
    .win_v4(v4), .win_v5(v5), .win_v6(v6), .win_v7(v7),
    .win_v8(v8), .win_row(win_row), .win_col(win_col),
    .win_valid(win_valid), .win_ready(win_ready)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  win_t q[$];
  logic [63:0] frm [ROWS][COLS];
  bit   mon_en = 0;
  bit   done_pend, done_seen, post_done, held_ok, fin;
  int   pops;
  win_t held;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // reference: plain neighbourhood lookup with out-of-range fill
  task automatic push_frame();
    win_t e;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        for (int k = 0; k < 9; k++) begin
          int rr, cc;
          rr = r + k / 3 - 1;
          cc = c + k % 3 - 1;
          if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS)
            e.v[k] = FILL;
          else
            e.v[k] = frm[rr][cc];
        end
        e.r = 3'(r);
        e.c = 2'(c);
        q.push_back(e);
      end
  endtask

  // monitor: pops expected windows on each handshake
  always @(negedge clk) begin
    if (mon_en) begin
      if (post_done) begin
        chk("done_width", 64'(frame_done), 64'd0);
        post_done = 0;
      end
      if (done_pend) begin
        chk("frame_done", 64'(frame_done), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd0);
        done_pend = 0;
        done_seen = 1;
        post_done = 1;
      end
      if (held_ok && win_valid) begin
        chk("stall_v4", v4, held.v[4]);
        chk("stall_pos", {win_row, win_col}, {held.r, held.c});
      end
      if (win_valid && !win_ready) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        held.v = gv;
        held.r = win_row;
        held.c = win_col;
        held_ok = 1;
      end else begin
        held_ok = 0;
      end
      if (win_valid && win_ready) begin
        if (q.size() == 0) begin
          chk("extra_window", 64'd1, 64'd0);
        end else begin
          win_t e;
          e = q.pop_front();
          pops++;
          chk("win_row", 64'(win_row), 64'(e.r));
          chk("win_col", 64'(win_col), 64'(e.c));
          for (int k = 0; k < 9; k++)
            chk($sformatf("v%0d(%0d,%0d)", k, e.r, e.c), gv[k], e.v[k]);
          if (q.size() == 0) done_pend = 1;
        end
      end
    end
  end

  // dmode 0: {R,C} pattern, 1: random; vmode 1: input gaps;
  // rmode 0: ready, 1: random, 2: 5-cycle stall; abort_at>0: reset
  task automatic run_frame(input int dmode, input int vmode,
                           input int rmode, input int abort_at);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        frm[r][c] = (dmode == 0) ? {48'h0, 8'(r), 8'(c)}
                                 : {$urandom, $urandom};
    q.delete();
    push_frame();
    pops = 0;
    done_pend = 0;
    done_seen = 0;
    post_done = 0;
    held_ok = 0;
    fin = 0;
    mon_en = 1;
    @(posedge clk); #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    fork
      begin : drv_in
        int  idx;
        bit  hs;
        idx = 0;
        while (!fin && idx < N) begin
          in_data  = frm[idx / COLS][idx % COLS];
          in_valid = (vmode == 0) || ($urandom_range(0, 2) != 0);
          @(negedge clk);
          hs = in_valid && in_ready;
          @(posedge clk); #1;
          if (hs) idx++;
        end
        in_valid = 0;
      end
      begin : drv_rdy
        int cyc;
        cyc = 0;
        while (!fin) begin
          case (rmode)
            0:       win_ready = 1;
            1:       win_ready = ($urandom_range(0, 3) != 0);
            default: win_ready = !(cyc >= 14 && cyc < 19);
          endcase
          @(posedge clk); #1;
          cyc++;
        end
        win_ready = 1;
      end
      begin : waiter
        int cyc;
        cyc = 0;
        while (!fin) begin
          @(negedge clk);
          cyc++;
          start = (cyc == 6);
          if (abort_at > 0 && pops >= abort_at) begin
            @(posedge clk); #1;
            rst = 1;
            mon_en = 0;
            q.delete();
            fin = 1;
            @(posedge clk); #1;
            chk("rst_win_valid", 64'(win_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
            rst = 0;
          end else if (done_seen) begin
            fin = 1;
          end else if (cyc > 3000) begin
            chk("timeout", 64'd1, 64'd0);
            fin = 1;
          end
        end
      end
    join
    repeat (2) @(posedge clk);
    #1;
    if (abort_at == 0) begin
      chk("windows_left", 64'(q.size()), 64'd0);
      chk("pops", 64'(pops), 64'(N));
      chk("idle_busy", 64'(busy), 64'd0);
    end
    mon_en = 0;
  endtask

  initial begin
    rst = 1;
    start = 0;
    in_valid = 0;
    in_data = 0;
    win_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_frame_done", 64'(frame_done), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_win_valid", 64'(win_valid), 64'd0);
    chk("reset_v4", v4, 64'd0);
    chk("reset_pos", {win_row, win_col}, 5'd0);
    win_ready = 1;
    in_valid = 1;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd0);
    in_valid = 0;

    run_frame(0, 0, 0, 0);
    run_frame(0, 1, 1, 0);
    run_frame(1, 0, 2, 0);
    run_frame(1, 1, 1, 0);
    run_frame(0, 0, 0, 10);
    run_frame(0, 1, 0, 0);
    run_frame(1, 1, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
